divisor_result_buffer: RTL and testbench

- Sits directly downstream of the pipelined signed divider.
- Captures each quotient/remainder pair on the divider's single-cycle done pulse and stores it in an in-order FIFO.
- Presents stored results to the consumer over a valid/ready handshake.
- Tracks divisions still in flight and gives the issuer a credit signal. The divider has no back-pressure, so any result it produces must always have a free slot.

---
 rtl/divisor_pkg.sv | 17 +
 rtl/divisor_fifo_mem.sv | 76 +++++++
 rtl/divisor_result_buffer.sv | 102 ++++++++++
 tb/tb_divisor_result_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// divisor_pkg
// Shared definitions for the signed divider and its result buffer.
//   TAMANYO_DEF     : default operand/result width.
//   PROFUNDIDAD_DEF : default result FIFO depth.
//   div_result_t    : quotient/remainder pair at the default width, as
//                     produced by the divider wrapper.
package divisor_pkg;

   localparam int unsigned TAMANYO_DEF     = 32;
   localparam int unsigned PROFUNDIDAD_DEF = 8;

   typedef struct packed {
      logic [TAMANYO_DEF-1:0] coc;
      logic [TAMANYO_DEF-1:0] res;
   } div_result_t;

endpackage

// File: rtl/divisor_fifo_mem.sv
// divisor_fifo_mem
// In-order result storage: array, read/write pointers and occupancy.
// Ports:
//   CLK       in   clock, rising edge
//   RSTa      in   asynchronous active-high reset
//   push      in   write wdata at the tail
//   pop       in   consume the head entry (ignored when empty)
//   wdata     in   entry to store
//   rdata     out  head entry (combinational read)
//   occupancy out  entries currently stored
//   drop      out  push refused because full with no pop this cycle
module divisor_fifo_mem #(
   parameter int unsigned W           = 64,
   parameter int unsigned PROFUNDIDAD = 8
) (
   input  logic                             CLK,
   input  logic                             RSTa,
   input  logic                             push,
   input  logic                             pop,
   input  logic [W-1:0]                     wdata,
   output logic [W-1:0]                     rdata,
   output logic [$clog2(PROFUNDIDAD+1)-1:0] occupancy,
   output logic                             drop
);

   localparam int unsigned PW = $clog2(PROFUNDIDAD);
   localparam int unsigned OW = $clog2(PROFUNDIDAD+1);

   logic [W-1:0]  mem_q [PROFUNDIDAD];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          full, empty, do_push, do_pop;

   assign full  = (occ_q == OW'(PROFUNDIDAD));
   assign empty = (occ_q == '0);

   // When full, a push is only taken if the head leaves in the same cycle;
   // the write then lands on the slot being vacated.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
         occ_d = occ_q + 1'b1;
      end else if (do_pop && !do_push) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RSTa) begin
      if (RSTa) begin
         for (int unsigned i = 0; i < PROFUNDIDAD; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= wdata;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign rdata     = mem_q[rd_ptr_q];
   assign occupancy = occ_q;

endmodule

// File: rtl/divisor_result_buffer.sv
// divisor_result_buffer
// Buffers quotient/remainder pairs from the pipelined signed divider and
// hands them to a consumer over valid/ready. Tracks divisions in flight so
// the issuer only starts a division when a slot is guaranteed.
// Ports:
//   CLK        in   clock, rising edge
//   RSTa       in   asynchronous active-high reset
//   Start      in   Start pulse also driven into the divider
//   Done       in   divider done pulse, Coc/Res valid this cycle
//   Coc, Res   in   divider quotient / remainder
//   Can_issue  out  another Start is permitted this cycle
//   Out_valid  out  head entry available
//   Out_ready  in   consumer takes the head entry
//   Out_coc    out  head quotient
//   Out_res    out  head remainder
//   Occupancy  out  entries currently stored
//   Overflow   out  sticky protocol-error flag
module divisor_result_buffer
   import divisor_pkg::*;
#(
   parameter int unsigned tamanyo     = TAMANYO_DEF,
   parameter int unsigned etapas      = tamanyo,
   parameter int unsigned PROFUNDIDAD = PROFUNDIDAD_DEF
) (
   input  logic                             CLK,
   input  logic                             RSTa,
   input  logic                             Start,
   input  logic                             Done,
   input  logic [tamanyo-1:0]               Coc,
   input  logic [tamanyo-1:0]               Res,
   output logic                             Can_issue,
   output logic                             Out_valid,
   input  logic                             Out_ready,
   output logic [tamanyo-1:0]               Out_coc,
   output logic [tamanyo-1:0]               Out_res,
   output logic [$clog2(PROFUNDIDAD+1)-1:0] Occupancy,
   output logic                             Overflow
);

   localparam int unsigned IW = $clog2(etapas+1);
   localparam int unsigned OW = $clog2(PROFUNDIDAD+1);
   localparam int unsigned CW = ((IW > OW) ? IW : OW) + 1;

   logic [IW-1:0]          inflight_q, inflight_d;
   logic                   overflow_q, overflow_d;
   logic                   done_ok, pop, drop;
   logic [CW-1:0]          credit_used;
   logic [2*tamanyo-1:0]   head;

   // A Done with nothing in flight belongs to a division started before
   // the last reset; it is discarded without flagging an error.
   assign done_ok = Done & (inflight_q != '0);
   assign pop     = Out_valid & Out_ready;

   always_comb begin
      inflight_d = inflight_q;
      if (Start && !done_ok) begin
         if (inflight_q != IW'(etapas)) inflight_d = inflight_q + 1'b1;
      end else if (done_ok && !Start) begin
         inflight_d = inflight_q - 1'b1;
      end
   end

   always_comb begin
      overflow_d = overflow_q | drop | (Start & ~Can_issue);
   end

   always_ff @(posedge CLK or posedge RSTa) begin
      if (RSTa) begin
         inflight_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         overflow_q <= overflow_d;
      end
   end

   divisor_fifo_mem #(
      .W          (2 * tamanyo),
      .PROFUNDIDAD(PROFUNDIDAD)
   ) u_fifo (
      .CLK      (CLK),
      .RSTa     (RSTa),
      .push     (done_ok),
      .pop      (pop),
      .wdata    ({Coc, Res}),
      .rdata    (head),
      .occupancy(Occupancy),
      .drop     (drop)
   );

   // Stored plus promised results must fit; registered terms only, so the
   // issuer sees a stable credit for the whole cycle.
   assign credit_used = CW'(Occupancy) + CW'(inflight_q);
   assign Can_issue   = (credit_used < CW'(PROFUNDIDAD));

   assign Out_valid = (Occupancy != '0);
   assign Out_coc   = head[2*tamanyo-1:tamanyo];
   assign Out_res   = head[tamanyo-1:0];
   assign Overflow  = overflow_q;

endmodule

// File: tb/tb_divisor_result_buffer.sv
module tb_divisor_result_buffer;
   import divisor_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned ET = 32;
   localparam int unsigned D  = 8;
   localparam int unsigned OW = $clog2(D+1);

   logic          CLK = 1'b0;
   logic          RSTa, Start, Done, Out_ready;
   logic [W-1:0]  Coc, Res, Out_coc, Out_res;
   logic          Can_issue, Out_valid, Overflow;
   logic [OW-1:0] Occupancy;

   always #5 CLK = ~CLK;

   divisor_result_buffer #(
      .tamanyo    (W),
      .etapas     (ET),
      .PROFUNDIDAD(D)
   ) dut (
      .CLK      (CLK),
      .RSTa     (RSTa),
      .Start    (Start),
      .Done     (Done),
      .Coc      (Coc),
      .Res      (Res),
      .Can_issue(Can_issue),
      .Out_valid(Out_valid),
      .Out_ready(Out_ready),
      .Out_coc  (Out_coc),
      .Out_res  (Out_res),
      .Occupancy(Occupancy),
      .Overflow (Overflow)
   );

   // Divider model: each Start produces a Done ET cycles later.
   typedef struct {
      int          due;
      logic [W-1:0] coc;
      logic [W-1:0] res;
   } sched_t;

   sched_t      sched_q[$];
   div_result_t exp_q[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   function automatic logic done_due();
      return (sched_q.size() != 0) && (sched_q[0].due == cyc);
   endfunction

   // One clock cycle: drive inputs, score any pop, then advance past the edge.
   task automatic cycle(input logic st, input logic [W-1:0] num, input logic [W-1:0] den,
                        input logic rdy, input logic track);
      sched_t      s;
      div_result_t e;
      while (sched_q.size() != 0 && sched_q[0].due < cyc) void'(sched_q.pop_front());
      Start = st; Out_ready = rdy; Done = 1'b0; Coc = '0; Res = '0;
      if (done_due()) begin
         s = sched_q.pop_front();
         Done = 1'b1; Coc = s.coc; Res = s.res;
      end
      if (Out_valid && rdy) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow: got %h/%h, required no entry", Out_coc, Out_res);
         end else begin
            e = exp_q.pop_front();
            if (Out_coc !== e.coc || Out_res !== e.res) begin
               bad++;
               $display("FAIL sb_data: got %h/%h, required %h/%h", Out_coc, Out_res, e.coc, e.res);
            end
         end
      end
      if (st) begin
         s.due = cyc + ET;
         s.coc = $signed(num) / $signed(den);
         s.res = $signed(num) % $signed(den);
         sched_q.push_back(s);
         if (track) begin
            e.coc = s.coc; e.res = s.res;
            exp_q.push_back(e);
         end
      end
      @(posedge CLK); #1; cyc++;
   endtask

   task automatic wait_done_next(input logic rdy);
      int n = 0;
      while (!done_due() && n < 200) begin
         cycle(1'b0, '0, 32'd1, rdy, 1'b0);
         n++;
      end
      total++;
      if (!done_due()) begin
         bad++;
         $display("FAIL wait_done: timeout, got no Done, required Done within 200 cycles");
      end
   endtask

   task automatic wait_sched_empty(input logic rdy);
      int n = 0;
      while (sched_q.size() != 0 && n < 200) begin
         cycle(1'b0, '0, 32'd1, rdy, 1'b0);
         n++;
      end
      total++;
      if (sched_q.size() != 0) begin
         bad++;
         $display("FAIL wait_sched: timeout, got %0d pending, required 0", sched_q.size());
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || sched_q.size() != 0) && n < 300) begin
         cycle(1'b0, '0, 32'd1, 1'b1, 1'b0);
         n++;
      end
      total++;
      if (Out_valid !== 1'b0 || Occupancy !== '0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got valid=%b occ=%0d left=%0d, required 0/0/0",
                  Out_valid, Occupancy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      RSTa = 1'b1; Start = 1'b0; Done = 1'b0; Out_ready = 1'b0; Coc = '0; Res = '0;
      repeat (2) @(posedge CLK);
      #1;
      total++; if (Out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", Out_valid); end
      total++; if (Occupancy !== '0) begin bad++; $display("FAIL rst_occ: got %0d, required 0", Occupancy); end
      total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b, required 0", Overflow); end
      total++; if (Out_coc !== '0 || Out_res !== '0) begin
         bad++; $display("FAIL rst_data: got %h/%h, required 0/0", Out_coc, Out_res);
      end
      RSTa = 1'b0;
      @(posedge CLK); #1; cyc++;
      total++; if (Can_issue !== 1'b1) begin bad++; $display("FAIL rst_credit: got %b, required 1", Can_issue); end
   endtask

   task automatic test_single();
      cycle(1'b1, 32'd100, 32'd7, 1'b1, 1'b1);
      wait_done_next(1'b1);
      cycle(1'b0, '0, 32'd1, 1'b1, 1'b0);   // Done cycle
      total++; if (Out_valid !== 1'b1 || Out_coc !== 32'd14 || Out_res !== 32'd2) begin
         bad++; $display("FAIL single_out: got v=%b %h/%h, required 1 14/2", Out_valid, Out_coc, Out_res);
      end
      cycle(1'b0, '0, 32'd1, 1'b1, 1'b0);   // pop
      total++; if (Occupancy !== '0 || Out_valid !== 1'b0) begin
         bad++; $display("FAIL single_empty: got occ=%0d v=%b, required 0/0", Occupancy, Out_valid);
      end
   endtask

   task automatic test_signed();
      cycle(1'b1, -32'sd100, 32'd7, 1'b0, 1'b1);
      cycle(1'b1, 32'd100, -32'sd7, 1'b0, 1'b1);
      wait_done_next(1'b0);
      cycle(1'b0, '0, 32'd1, 1'b0, 1'b0);
      total++; if (Out_coc !== 32'hFFFF_FFF2 || Out_res !== 32'hFFFF_FFFE) begin
         bad++; $display("FAIL signed_neg: got %h/%h, required fffffff2/fffffffe", Out_coc, Out_res);
      end
      cycle(1'b0, '0, 32'd1, 1'b0, 1'b0);
      total++; if (Out_coc !== 32'hFFFF_FFF2 || Occupancy !== OW'(2)) begin
         bad++; $display("FAIL signed_hold: got %h occ=%0d, required fffffff2 occ=2", Out_coc, Occupancy);
      end
      drain();
   endtask

   task automatic test_back_pressure();
      int acc = 0;
      for (int i = 0; i < 12; i++) begin
         if (Can_issue) begin
            cycle(1'b1, 1000 + i * 37, i + 3, 1'b0, 1'b1);
            acc++;
         end else begin
            cycle(1'b0, '0, 32'd1, 1'b0, 1'b0);
         end
      end
      total++; if (acc != 8) begin bad++; $display("FAIL bp_accepted: got %0d, required 8", acc); end
      total++; if (Can_issue !== 1'b0 || Occupancy !== '0) begin
         bad++; $display("FAIL bp_inflight: got credit=%b occ=%0d, required 0/0", Can_issue, Occupancy);
      end
      wait_sched_empty(1'b0);
      total++; if (Occupancy !== OW'(8) || Overflow !== 1'b0 || Can_issue !== 1'b0) begin
         bad++; $display("FAIL bp_full: got occ=%0d ovf=%b credit=%b, required 8/0/0",
                         Occupancy, Overflow, Can_issue);
      end
      cycle(1'b0, '0, 32'd1, 1'b1, 1'b0);
      total++; if (Occupancy !== OW'(7) || Can_issue !== 1'b1) begin
         bad++; $display("FAIL bp_credit: got occ=%0d credit=%b, required 7/1", Occupancy, Can_issue);
      end
      drain();
   endtask

   task automatic test_full_simultaneous();
      int n = 0;
      for (int i = 0; i < 8; i++) cycle(1'b1, 500 + i, 32'd9, 1'b0, 1'b1);
      total++; if (Can_issue !== 1'b0) begin bad++; $display("FAIL fs_credit: got %b, required 0", Can_issue); end
      // Credit never allows a ninth result while eight are stored, so this
      // scenario needs one over-credit Start.
      cycle(1'b1, 32'd777, 32'd10, 1'b0, 1'b1);
      while (!(Occupancy == OW'(8) && done_due()) && n < 200) begin
         cycle(1'b0, '0, 32'd1, 1'b0, 1'b0);
         n++;
      end
      total++; if (n >= 200) begin bad++; $display("FAIL fs_wait: timeout, got occ=%0d, required 8", Occupancy); end
      cycle(1'b0, '0, 32'd1, 1'b1, 1'b0);   // pop head and push 777/10 together
      total++; if (Occupancy !== OW'(8)) begin bad++; $display("FAIL fs_occ: got %0d, required 8", Occupancy); end
      total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL fs_ovf: got %b, required 1", Overflow); end
      drain();
   endtask

   task automatic test_reset_mid_stream();
      int n = 0;
      for (int i = 0; i < 8; i++) cycle(1'b1, 200 + i * 11, 32'd5, 1'b0, 1'b1);
      while (Occupancy != OW'(3) && n < 200) begin
         cycle(1'b0, '0, 32'd1, 1'b0, 1'b0);
         n++;
      end
      total++; if (Occupancy !== OW'(3)) begin bad++; $display("FAIL rm_pre: got %0d, required 3", Occupancy); end
      Start = 1'b0; Done = 1'b0;
      RSTa = 1'b1;
      #2;
      total++; if (Out_valid !== 1'b0 || Occupancy !== '0 || Overflow !== 1'b0) begin
         bad++; $display("FAIL rm_async: got v=%b occ=%0d ovf=%b, required 0/0/0",
                         Out_valid, Occupancy, Overflow);
      end
      exp_q.delete();
      RSTa = 1'b0;
      @(posedge CLK); #1; cyc++;
      wait_sched_empty(1'b1);
      cycle(1'b0, '0, 32'd1, 1'b1, 1'b0);
      total++; if (Occupancy !== '0 || Out_valid !== 1'b0 || Overflow !== 1'b0 || Can_issue !== 1'b1) begin
         bad++; $display("FAIL rm_stale: got occ=%0d v=%b ovf=%b credit=%b, required 0/0/0/1",
                         Occupancy, Out_valid, Overflow, Can_issue);
      end
   endtask

   task automatic test_protocol_violation();
      for (int i = 0; i < 8; i++) cycle(1'b1, 300 + i * 3, 32'd4, 1'b0, 1'b1);
      wait_sched_empty(1'b0);
      total++; if (Occupancy !== OW'(8) || Overflow !== 1'b0) begin
         bad++; $display("FAIL pv_pre: got occ=%0d ovf=%b, required 8/0", Occupancy, Overflow);
      end
      cycle(1'b1, 32'd999, 32'd3, 1'b0, 1'b0);   // forced, result must be dropped
      total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL pv_start: got %b, required 1", Overflow); end
      wait_sched_empty(1'b0);
      cycle(1'b0, '0, 32'd1, 1'b0, 1'b0);
      total++; if (Occupancy !== OW'(8) || Overflow !== 1'b1) begin
         bad++; $display("FAIL pv_drop: got occ=%0d ovf=%b, required 8/1", Occupancy, Overflow);
      end
      drain();
      total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL pv_sticky: got %b, required 1", Overflow); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_signed();
      test_back_pressure();
      test_full_simultaneous();
      test_reset_mid_stream();
      test_protocol_violation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
